// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer arbiter: fixed-latency VGA reads, FIFO-buffered camera writes
// Optional bank swapping is built when FB_DOUBLE_BUFFER_EN is defined.
module fb_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 12,
    parameter int FIFO_AW = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FB_DOUBLE_BUFFER_EN
    input  logic                cam_frame_done,
    input  logic                vga_vblank,
`endif
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_ready,
    output logic [ADDR_W:0]     mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];
    logic [DATA_W-1:0]  fifo_data_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic               fifo_full, fifo_empty;
    logic               pop, push, drop;
    logic               bank_rd, bank_wr;

    logic [ADDR_W:0]    mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               rd_p1_q, rd_p2_q, rd_valid_q;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);

    // Reads always win the port; a full FIFO still accepts a push when it pops the same cycle.
    assign pop  = !rd_req && !fifo_empty;
    assign push = wr_valid && (!fifo_full || pop);
    assign drop = wr_valid && fifo_full && !pop;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic [1:0] ST_SHOW = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_SWAP = 2'd2;

    logic [1:0] state_q, state_d;
    logic       disp_q, disp_d;

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        case (state_q)
            ST_SHOW: if (cam_frame_done) state_d = ST_PEND;
            // Wait until every pixel of the finished frame has landed in the back bank.
            ST_PEND: if (vga_vblank && fifo_empty) state_d = ST_SWAP;
            ST_SWAP: begin
                disp_d  = ~disp_q;
                state_d = ST_SHOW;
            end
            default: state_d = ST_SHOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SHOW;
            disp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
        end
    end

    assign bank_rd = disp_q;
    assign bank_wr = ~disp_q;
`else
    assign bank_rd = 1'b0;
    assign bank_wr = 1'b0;
`endif

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (rd_req) begin
            mem_addr_d = {bank_rd, rd_addr};
        end else if (pop) begin
            mem_addr_d  = {bank_wr, fifo_addr_q[rptr_q]};
            mem_wdata_d = fifo_data_q[rptr_q];
            mem_we_d    = 1'b1;
        end
    end

    always_comb begin
        wptr_d     = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d     = pop  ? rptr_q + PTR_ONE : rptr_q;
        overflow_d = overflow_q | drop;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
        rd_data_d = rd_p2_q ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr;
            fifo_data_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rd_p1_q     <= rd_req;
            rd_p2_q     <= rd_p1_q;
            rd_valid_q  <= rd_p2_q;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign wr_ready   = !fifo_full;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - directed scoreboard bench for fb_arbiter
module tb_fb_arbiter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        wr_valid;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [4:0]  fifo_level;
    logic        overflow;
`ifdef FB_DOUBLE_BUFFER_EN
    logic        cam_frame_done = 1'b0;
    logic        vga_vblank = 1'b0;
`endif

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FB_DOUBLE_BUFFER_EN
        .cam_frame_done (cam_frame_done),
        .vga_vblank     (vga_vblank),
`endif
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          c;
        logic [17:0] a;
        logic [11:0] d;
    } rexp_t;

    typedef struct {
        logic [16:0] a;
        logic [11:0] d;
    } wexp_t;

    rexp_t raq[$];
    rexp_t rdq[$];
    wexp_t wq[$];
    int    m_lvl;
    logic  m_ovf;

    logic [11:0] ram [bit [17:0]];

    function automatic logic [11:0] pat(input logic [17:0] a);
        return a[11:0] ^ {a[17:12], a[17:12]} ^ 12'hA5C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM, one cycle read latency, preloaded with an address pattern.
    always @(posedge clk) begin
        bit [17:0] a;
        a = mem_addr;
        mem_rdata <= ram.exists(a) ? ram[a] : pat(a);
        if (mem_we === 1'b1) ram[a] = mem_wdata;
    end

    always @(negedge clk) begin
        if (raq.size() > 0 && raq[0].c == cyc) begin
            chk("rd_mem_addr", 32'(mem_addr), 32'(raq[0].a));
            chk("rd_mem_we", 32'(mem_we), 32'(0));
            void'(raq.pop_front());
        end
        if (rd_valid === 1'b1) begin
            if (rdq.size() == 0) begin
                chk("spurious_rd_valid", 32'(rd_valid), 32'(0));
            end else begin
                chk("rd_valid_cycle", 32'(cyc), 32'(rdq[0].c));
                chk("rd_data", 32'(rd_data), 32'(rdq[0].d));
                void'(rdq.pop_front());
            end
        end else if (rdq.size() > 0 && rdq[0].c <= cyc) begin
            chk("rd_valid_missing", 32'(rd_valid), 32'(1));
            void'(rdq.pop_front());
        end
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("spurious_mem_we", 32'(mem_we), 32'(0));
            end else begin
                chk("wr_mem_addr", 32'(mem_addr), 32'({1'b0, wq[0].a}));
                chk("wr_mem_wdata", 32'(mem_wdata), 32'(wq[0].d));
                void'(wq.pop_front());
            end
        end
    end

    task automatic step(input logic rq, input logic [16:0] ra, input logic wv,
                        input logic [16:0] wa, input logic [11:0] wd);
        bit pop;
        bit push;
        rd_req   = rq;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        pop  = !rq && (m_lvl > 0);
        push = wv && ((m_lvl < DEPTH) || pop);
        if (rq) begin
            raq.push_back('{cyc + 1, {1'b0, ra}, 12'h000});
            rdq.push_back('{cyc + 3, {1'b0, ra}, pat({1'b0, ra})});
        end
        if (push) wq.push_back('{wa, wd});
        @(posedge clk);
        #1;
        m_lvl = m_lvl + int'(push) - int'(pop);
        if (wv && !push) m_ovf = 1'b1;
        chk("fifo_level", 32'(fifo_level), 32'(m_lvl));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("wr_ready", 32'(wr_ready), 32'(m_lvl != DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 17'h0, 1'b0, 17'h0, 12'h0);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        raq.delete();
        rdq.delete();
        wq.delete();
        m_lvl = 0;
        m_ovf = 1'b0;
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_fifo_level", 32'(fifo_level), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        rd_req = 1'b0;
        rd_addr = '0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        m_lvl = 0;
        m_ovf = 1'b0;
        do_reset(3);

        // Single read: address out one cycle later, data three cycles later.
        idle(5);
        step(1'b1, 17'h00123, 1'b0, 17'h0, 12'h0);
        idle(5);

        // Pixel-rate reads interleaved with a burst of 8 writes.
        for (int i = 0; i < 8; i++)
            step((i % 2) == 0, 17'h02000 + 17'(i), 1'b1, 17'h00100 + 17'(i), 12'h300 + 12'(i));
        idle(10);

        // Fill to exactly full under reads, then pop and push together.
        do_reset(1);
        for (int i = 0; i < 16; i++)
            step(1'b1, 17'h04000 + 17'(i), 1'b1, 17'h00500 + 17'(i), 12'h500 + 12'(i));
        step(1'b0, 17'h0, 1'b1, 17'h00510, 12'h5AA);
        idle(20);

        // Reads starve writes for 40 cycles: FIFO saturates and drops the excess.
        for (int i = 0; i < 40; i++)
            step(1'b1, 17'h06000 + 17'(i), 1'b1, 17'h00700 + 17'(i), 12'h700 + 12'(i));
        idle(20);

        // Reset one cycle after a read with three words queued.
        do_reset(1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 17'h08000 + 17'(i), 1'b1, 17'h00900 + 17'(i), 12'h900 + 12'(i));
        step(1'b1, 17'h08003, 1'b0, 17'h0, 12'h0);
        do_reset(1);
        idle(6);

        n = 0;
        while ((wq.size() > 0 || rdq.size() > 0) && n < 50) begin
            idle(1);
            n++;
        end
        chk("pending_writes", 32'(wq.size()), 32'(0));
        chk("pending_reads", 32'(rdq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Schedules one single-port synchronous framebuffer RAM between two requesters: the VGA pixel reader and the camera pixel writer.
- VGA reads have absolute priority and a fixed latency. Camera writes are buffered in a small FIFO and drained into idle RAM slots.
- Sits between the camera capture logic, the VGA timing generator and the framebuffer BRAM. Runs on the 100 MHz system clock.

Parameters:
- ADDR_W, 17: framebuffer word address width (one word per pixel).
- DATA_W, 12: pixel width (RGB444).
- FIFO_AW, 4: log2 of write FIFO depth (depth 16).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- rd_req, input, 1: VGA pixel read request, sampled each cycle.
- rd_addr, input, ADDR_W: VGA read address, valid with rd_req.
- rd_data, output, DATA_W: read pixel, valid with rd_valid.
- rd_valid, output, 1: read data valid.
- wr_valid, input, 1: camera pixel write strobe.
- wr_addr, input, ADDR_W: camera write address.
- wr_data, input, DATA_W: camera write pixel.
- wr_ready, output, 1: FIFO not full (informational; camera has no backpressure).
- mem_addr, output, ADDR_W+1: RAM address. MSB is the bank bit.
- mem_we, output, 1: RAM write enable.
- mem_wdata, output, DATA_W: RAM write data.
- mem_rdata, input, DATA_W: RAM read data, 1-cycle latency after mem_addr.
- fifo_level, output, FIFO_AW+1: current FIFO occupancy.
- overflow, output, 1: sticky flag, set when a write is dropped.

Behaviour:
- Reset (synchronous): all outputs 0 (rd_data, rd_valid, mem_addr, mem_we, mem_wdata, fifo_level, overflow). FIFO emptied. Read pipeline flushed. Bank state cleared. Applies even mid-transfer; in-flight reads never produce rd_valid.
- Port slot decision is made each cycle t, registered onto the mem_* outputs at t+1:
  - rd_req=1: read slot. mem_addr={bank_rd, rd_addr}, mem_we=0.
  - else FIFO not empty: write slot. Pop head; mem_addr={bank_wr, head addr}, mem_wdata=head data, mem_we=1.
  - else: idle slot, mem_we=0. mem_addr/mem_wdata hold their previous values.
- Read latency is fixed at 3: rd_req at t -> mem_addr at t+1 -> mem_rdata at t+2 -> rd_data registered with rd_valid=1 at t+3.
  - rd_valid is a 1-cycle pulse per request.
  - rd_data holds its value between pulses.
- Back-to-back rd_req is legal every cycle. Writes then starve and the FIFO fills; no read is ever delayed.
- FIFO:
  - Depth 2^FIFO_AW entries of {addr, data}, first-word fall-through head.
  - wr_ready = (fifo_level != depth).
  - wr_valid while not full: push.
  - Simultaneous push and pop: level unchanged; legal when full (pop frees the slot in the same cycle, so the push is accepted).
  - wr_valid while full with no pop that cycle: word dropped, overflow<=1 (cleared only by rst).
  - Pointers wrap modulo depth. fifo_level ranges 0..depth.
- Write ordering is preserved: RAM writes occur in exact push order.
- Read/write hazard: a read of an address with a pending FIFO write returns old RAM contents. This is accepted and not forwarded.
- Without the optional feature, the mem_addr MSB is constant 0.

Optional Feature:
- Macro: FB_DOUBLE_BUFFER_EN.
- With the macro: the RAM holds two banks. Extra inputs cam_frame_done (1-cycle pulse) and vga_vblank (level). bank_rd = disp, bank_wr = ~disp. FSM:
  - SHOW: on cam_frame_done -> PEND.
  - PEND: when vga_vblank=1 and FIFO empty -> SWAP.
  - SWAP: 1 cycle, disp<=~disp, -> SHOW.
  - cam_frame_done in PEND or SWAP is ignored.
  - Reset: SHOW, disp=0.
  - Writes popped in PEND still target ~disp.
- Without the macro: extra ports absent, no FSM, single bank, bank bit 0.

Test Plan:
- Reset, then rd_req=1 with rd_addr=0x00123 at cycle 10 -> mem_addr=0x00123, mem_we=0 at 11; rd_valid=1 with rd_data equal to RAM[0x123] at 13. No other rd_valid pulses.
- rd_req alternating 1/0 (VGA pixel rate) plus wr_valid every cycle for 8 words, addr 0x100..0x107 -> all 8 written in order in rd_req=0 slots. fifo_level peaks at ≤5 and returns to 0. overflow=0.
- rd_req held 1 for 40 cycles, wr_valid every cycle -> fifo_level saturates at 16, wr_ready=0, overflow=1. First 16 words are written after rd_req drops; the rest are dropped.
- Full FIFO with a simultaneous pop and push (rd_req=0, wr_valid=1) -> push accepted, fifo_level stays 16, overflow unchanged.
- rst asserted 1 cycle after an rd_req with 3 words queued -> no rd_valid, fifo_level=0, mem_we=0 the cycle after rst.
- FB_DOUBLE_BUFFER_EN: cam_frame_done with FIFO holding 2 words and vga_vblank=1 -> swap occurs only after the FIFO empties. Subsequent reads use mem_addr MSB=1 and writes use MSB=0.
